// File: rtl/step_ctrl.sv
// rtl/step_ctrl.sv - run/single-step controller issuing processor enable pulses
// Slow-clock edges become one-cycle proc_en pulses, gated by run/step/halt.
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic        clk_27,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic        run,
  input  logic        step_n,
  input  logic        halt,
  output logic        proc_en,
  output logic [15:0] step_count,
  output logic [1:0]  state
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10,
    HALTED    = 2'b11
  } state_t;

  state_t        st;
  logic          slow_m, slow_s, slow_prev;
  logic          run_m, run_s;
  logic          step_m, step_s;
  logic          btn_db, btn_prev;
  logic [CW-1:0] db_cnt;
  logic          rise, press;

  // The button path idles high so reset never looks like a press.
  always_ff @(posedge clk_27) begin
    if (reset) begin
      slow_m    <= 1'b0;
      slow_s    <= 1'b0;
      slow_prev <= 1'b0;
      run_m     <= 1'b0;
      run_s     <= 1'b0;
      step_m    <= 1'b1;
      step_s    <= 1'b1;
    end else begin
      slow_m    <= slow_clk;
      slow_s    <= slow_m;
      slow_prev <= slow_s;
      run_m     <= run;
      run_s     <= run_m;
      step_m    <= step_n;
      step_s    <= step_m;
    end
  end

  assign rise  = slow_s & ~slow_prev;
  assign press = btn_prev & ~btn_db;

  always_ff @(posedge clk_27) begin
    if (reset) begin
      btn_db   <= 1'b1;
      btn_prev <= 1'b1;
      db_cnt   <= '0;
    end else begin
      btn_prev <= btn_db;
      if (step_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= step_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

  // halt outranks everything but reset; HALTED is absorbing.
  always_ff @(posedge clk_27) begin
    if (reset) begin
      st      <= IDLE;
      proc_en <= 1'b0;
    end else begin
      proc_en <= 1'b0;
      if (halt) begin
        st <= HALTED;
      end else begin
        case (st)
          IDLE: begin
            if (run_s)      st <= RUN;
            else if (press) st <= STEP_WAIT;
          end
          RUN: begin
            if (!run_s)    st <= IDLE;
            else if (rise) proc_en <= 1'b1;
          end
          STEP_WAIT: begin
            if (rise) begin
              proc_en <= 1'b1;
              st      <= IDLE;
            end
          end
          default: st <= HALTED;
        endcase
      end
    end
  end

  always_ff @(posedge clk_27) begin
    if (reset)        step_count <= 16'd0;
    else if (proc_en) step_count <= step_count + 16'd1;
  end

  assign state = st;
endmodule

// File: tb/tb_step_ctrl.sv
// tb/tb_step_ctrl.sv - randomized and directed bench for step_ctrl against a sample-history model
module tb_step_ctrl;
  localparam int D           = 4;
  localparam int SLOW_PERIOD = 20;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        reset, slow_clk, run, step_n, halt;
  logic        proc_en;
  logic [15:0] step_count;
  logic [1:0]  state;

  step_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_27(clk), .reset(reset), .slow_clk(slow_clk), .run(run),
    .step_n(step_n), .halt(halt), .proc_en(proc_en),
    .step_count(step_count), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: hs/hr/hst[0] = input sampled one edge ago, [1] two edges ago, [2] three.
  bit          hs[3], hr[3], hst[3];
  bit          acc, m_press, m_pen, model_valid = 1'b0;
  int          mm;
  logic [15:0] m_cnt;
  logic [1:0]  m_state;
  bit          rise_now, run_now, press_now, pen_next;
  logic [1:0]  st_next;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        hs[i] = 1'b0; hr[i] = 1'b0; hst[i] = 1'b1;
      end
      acc = 1'b1; mm = 0; m_press = 1'b0;
      m_pen = 1'b0; m_cnt = 16'd0; m_state = S_IDLE;
      model_valid = 1'b1;
    end else begin
      rise_now  = hs[1] && !hs[2];
      run_now   = hr[1];
      press_now = m_press;
      m_press   = 1'b0;
      if (hst[1] != acc) begin
        mm++;
        if (mm == D) begin
          m_press = acc;
          acc     = hst[1];
          mm      = 0;
        end
      end else begin
        mm = 0;
      end
      pen_next = 1'b0;
      st_next  = m_state;
      if (m_state != S_HALT && halt) st_next = S_HALT;
      else begin
        case (m_state)
          S_IDLE: if (run_now) st_next = S_RUN; else if (press_now) st_next = S_STEP;
          S_RUN:  if (!run_now) st_next = S_IDLE; else pen_next = rise_now;
          S_STEP: if (rise_now) begin pen_next = 1'b1; st_next = S_IDLE; end
          default: ;
        endcase
      end
      if (m_pen) m_cnt = m_cnt + 16'd1;
      m_pen   = pen_next;
      m_state = st_next;
      hs[2] = hs[1];   hs[1] = hs[0];   hs[0] = slow_clk;
      hr[2] = hr[1];   hr[1] = hr[0];   hr[0] = run;
      hst[2] = hst[1]; hst[1] = hst[0]; hst[0] = step_n;
    end
  end

  logic prev_pen = 1'b0;
  always @(negedge clk) begin
    if (model_valid) begin
      check("proc_en", proc_en, m_pen);
      check("step_count", step_count, m_cnt);
      check("state", state, m_state);
      check("pulse_width", proc_en & prev_pen, 1'b0);
      prev_pen = proc_en;
    end
  end

  int slow_ph  = 0;
  bit slow_on  = 1'b0;
  bit slow_rose;

  task automatic tick();
    @(negedge clk);
    slow_rose = 1'b0;
    if (!slow_on) begin
      slow_ph  = 0;
      slow_clk = 1'b0;
    end else begin
      slow_rose = (slow_ph == 0);
      slow_clk  = (slow_ph < SLOW_PERIOD / 2);
      slow_ph   = (slow_ph + 1) % SLOW_PERIOD;
    end
  endtask

  task automatic count_pulses(input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (proc_en) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int p, first, waited;
  bit saw_step, left_idle;

  initial begin
    reset = 1'b1; slow_clk = 1'b0; run = 1'b0; step_n = 1'b1; halt = 1'b0;
    tick(); tick(); tick();
    check("reset_state", state, S_IDLE);
    check("reset_count", step_count, 16'd0);
    check("reset_pen", proc_en, 1'b0);
    reset = 1'b0;

    // Free run over five slow periods.
    run = 1'b1;
    repeat (4) tick();
    check("t1_in_run", state, S_RUN);
    slow_on = 1'b1;
    count_pulses(100, p, first);
    check("t1_pulses", p, 5);
    check("t1_latency", first, 4);
    check("t1_count", step_count, 16'd5);
    check("t1_state", state, S_RUN);

    // Bouncy press in step mode yields exactly one step.
    run = 1'b0;
    repeat (3) tick();
    check("t2_idle", state, S_IDLE);
    for (int i = 0; i < 3; i++) begin
      step_n = 1'b0; tick();
      step_n = 1'b1; tick();
    end
    p = 0; saw_step = 1'b0;
    step_n = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) step_n = 1'b1;
      tick();
      if (proc_en) p++;
      if (state == S_STEP) saw_step = 1'b1;
    end
    check("t2_pulses", p, 1);
    check("t2_saw_step_wait", saw_step, 1'b1);
    check("t2_count", step_count, 16'd6);
    check("t2_state", state, S_IDLE);

    // Short glitch is rejected.
    step_n = 1'b0;
    repeat (3) tick();
    step_n = 1'b1;
    p = 0; left_idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (proc_en) p++;
      if (state != S_IDLE) left_idle = 1'b1;
    end
    check("t3_pulses", p, 0);
    check("t3_stayed_idle", left_idle, 1'b0);

    // halt coincident with rise in RUN, then absorbing until reset.
    run = 1'b1;
    repeat (4) tick();
    check("t4_in_run", state, S_RUN);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!slow_rose && waited < 40);
    check("t4_found_rise", slow_rose, 1'b1);
    tick(); tick();
    halt = 1'b1;
    p = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 10) halt = 1'b0;
      if (i == 20) run = 1'b0;
      if (i == 30) step_n = 1'b0;
      if (i == 45) step_n = 1'b1;
      if (i == 50) run = 1'b1;
      tick();
      if (proc_en) p++;
    end
    check("t4_no_pulses", p, 0);
    check("t4_halted", state, S_HALT);
    slow_on = 1'b0;
    do_reset();
    check("t4_reset_state", state, S_IDLE);
    check("t4_reset_count", step_count, 16'd0);

    // Counter wrap.
    run = 1'b1;
    repeat (4) tick();
    force dut.step_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    tick();
    release dut.step_count;
    tick();
    check("t5_preload", step_count, 16'hFFFE);
    slow_on = 1'b1;
    count_pulses(10, p, first);
    check("t5_pulse_a", p, 1);
    check("t5_ffff", step_count, 16'hFFFF);
    count_pulses(20, p, first);
    check("t5_pulse_b", p, 1);
    check("t5_wrap", step_count, 16'h0000);

    // Reset while waiting in STEP_WAIT, one cycle before the rise.
    slow_on = 1'b0;
    run = 1'b0;
    do_reset();
    step_n = 1'b0;
    repeat (10) tick();
    step_n = 1'b1;
    tick();
    check("t6_step_wait", state, S_STEP);
    slow_on = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("t6_state_after_reset", state, S_IDLE);
    check("t6_pen_after_reset", proc_en, 1'b0);
    reset = 1'b0;
    count_pulses(40, p, first);
    check("t6_no_pulses", p, 0);
    check("t6_idle", state, S_IDLE);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) reset = ($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if ($urandom_range(0, 199) == 0) run = ~run;
      if (!halt && $urandom_range(0, 2999) == 0) halt = 1'b1;
      else if (halt && $urandom_range(0, 49) == 0) halt = 1'b0;
      if ($urandom_range(0, 29) == 0) step_n = ~step_n;
      else if ($urandom_range(0, 99) == 0) step_n = ~step_n;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
